// File: rtl/alu_shifter_pkg.sv
// Shared types for the execute-stage ALU/shifter: opcodes, shift kinds, operand-2 modes,
// and flag bit positions.
package alu_shifter_pkg;

  typedef enum logic [3:0] {
    OpAnd = 4'b0000,
    OpEor = 4'b0001,
    OpSub = 4'b0010,
    OpRsb = 4'b0011,
    OpAdd = 4'b0100,
    OpAdc = 4'b0101,
    OpSbc = 4'b0110,
    OpRsc = 4'b0111,
    OpTst = 4'b1000,
    OpTeq = 4'b1001,
    OpCmp = 4'b1010,
    OpCmn = 4'b1011,
    OpOrr = 4'b1100,
    OpMov = 4'b1101,
    OpBic = 4'b1110,
    OpMvn = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ShLsl = 2'b00,
    ShLsr = 2'b01,
    ShAsr = 2'b10,
    ShRor = 2'b11
  } shift_kind_e;

  // Operand-2 addressing modes; any value with bit 2 set passes rm through.
  localparam logic [2:0] ShTypeDpImm = 3'b000;
  localparam logic [2:0] ShTypeImm   = 3'b001;
  localparam logic [2:0] ShTypeLsImm = 3'b010;
  localparam logic [2:0] ShTypeLsReg = 3'b011;

  localparam int unsigned FlagV = 0;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagN = 3;

endpackage

// File: rtl/alu_shifter_unit_if.sv
// Execute-stage operand/result bundle between the ID/EX registers and the ALU/shifter unit.
interface alu_shifter_unit_if;
  logic        en;
  logic [3:0]  opcode;
  logic [31:0] rn;
  logic [31:0] rm;
  logic [11:0] shift_field;
  logic [2:0]  shift_type;
  logic        carry_in;
  logic [31:0] result;
  logic [3:0]  flags;

  modport master (
    output en, opcode, rn, rm, shift_field, shift_type, carry_in,
    input  result, flags
  );

  modport slave (
    input  en, opcode, rn, rm, shift_field, shift_type, carry_in,
    output result, flags
  );
endinterface

// File: rtl/operand_shifter.sv
// Combinational operand-2 shifter producing the B operand and shifter carry-out.
// Define ALU_SHIFTER_RRX_EN to make ROR #0 behave as RRX.
module operand_shifter
  import alu_shifter_pkg::*;
(
  input  logic [31:0] rm,
  input  logic [11:0] shift_field,
  input  logic [2:0]  shift_type,
  input  logic        carry_in,
  output logic [31:0] value,
  output logic        shc
);

  logic [4:0]  amt;
  logic [5:0]  amt_inv;
  shift_kind_e kind;
  logic [32:0] lsl_t;
  logic [32:0] lsr_t;
  logic [32:0] asr_t;
  logic [31:0] ror_t;
  logic [31:0] imm8;
  logic [4:0]  imm_rot;
  logic [5:0]  imm_rot_inv;
  logic [31:0] imm_t;

  always_comb begin
    amt         = shift_field[11:7];
    amt_inv     = 6'd32 - {1'b0, amt};
    kind        = shift_kind_e'(shift_field[6:5]);
    // Extra bit beyond the shifted word catches the last bit shifted out.
    lsl_t       = {1'b0, rm} << amt;
    lsr_t       = {rm, 1'b0} >> amt;
    asr_t       = $signed({rm, 1'b0}) >>> amt;
    ror_t       = (rm >> amt) | (rm << amt_inv);
    imm8        = {24'b0, shift_field[7:0]};
    imm_rot     = {shift_field[11:8], 1'b0};
    imm_rot_inv = 6'd32 - {1'b0, imm_rot};
    imm_t       = (imm8 >> imm_rot) | (imm8 << imm_rot_inv);

    value = rm;
    shc   = carry_in;

    if (!shift_type[2]) begin
      case (shift_type)
        ShTypeDpImm, ShTypeLsReg: begin
          case (kind)
            ShLsl: begin
              value = lsl_t[31:0];
              shc   = (amt == 5'd0) ? carry_in : lsl_t[32];
            end
            ShLsr: begin
              // #0 encodes a shift by 32.
              value = (amt == 5'd0) ? 32'd0 : lsr_t[32:1];
              shc   = (amt == 5'd0) ? rm[31] : lsr_t[0];
            end
            ShAsr: begin
              value = (amt == 5'd0) ? {32{rm[31]}} : asr_t[32:1];
              shc   = (amt == 5'd0) ? rm[31] : asr_t[0];
            end
            default: begin
              if (amt != 5'd0) begin
                value = ror_t;
                shc   = ror_t[31];
              end else begin
`ifdef ALU_SHIFTER_RRX_EN
                value = {carry_in, rm[31:1]};
                shc   = rm[0];
`else
                value = rm;
                shc   = carry_in;
`endif
              end
            end
          endcase
        end
        ShTypeImm: begin
          value = imm_t;
          shc   = (imm_rot == 5'd0) ? carry_in : imm_t[31];
        end
        default: begin
          value = {20'b0, shift_field};
          shc   = carry_in;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_shifter_unit.sv
// Registered EX-stage datapath: operand shifter feeding a 16-opcode ALU, result and NZCV
// registered on enabled edges. ALU_SHIFTER_RRX_EN selects RRX for ROR #0 in the shifter.
module alu_shifter_unit
  import alu_shifter_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  alu_shifter_unit_if.slave bus
);

  logic [31:0] b_val;
  logic        shc;
  alu_op_e     op;
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic        add_ci;
  logic [32:0] sum;
  logic        arith;
  logic [31:0] result_d, result_q;
  logic [3:0]  flags_d, flags_q;

  operand_shifter u_shifter (
    .rm          (bus.rm),
    .shift_field (bus.shift_field),
    .shift_type  (bus.shift_type),
    .carry_in    (bus.carry_in),
    .value       (b_val),
    .shc         (shc)
  );

  always_comb begin
    op       = alu_op_e'(bus.opcode);
    add_x    = bus.rn;
    add_y    = b_val;
    add_ci   = 1'b0;
    arith    = 1'b0;
    result_d = '0;

    // Subtracts are x + ~y + carry, so bit 32 of the sum is directly NOT borrow.
    case (op)
      OpAdd, OpCmn: arith = 1'b1;
      OpAdc: begin
        arith  = 1'b1;
        add_ci = bus.carry_in;
      end
      OpSub, OpCmp: begin
        arith  = 1'b1;
        add_y  = ~b_val;
        add_ci = 1'b1;
      end
      OpSbc: begin
        arith  = 1'b1;
        add_y  = ~b_val;
        add_ci = bus.carry_in;
      end
      OpRsb: begin
        arith  = 1'b1;
        add_x  = b_val;
        add_y  = ~bus.rn;
        add_ci = 1'b1;
      end
      OpRsc: begin
        arith  = 1'b1;
        add_x  = b_val;
        add_y  = ~bus.rn;
        add_ci = bus.carry_in;
      end
      default: ;
    endcase

    sum = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_ci};

    case (op)
      OpAnd, OpTst: result_d = bus.rn & b_val;
      OpEor, OpTeq: result_d = bus.rn ^ b_val;
      OpOrr:        result_d = bus.rn | b_val;
      OpBic:        result_d = bus.rn & ~b_val;
      OpMov:        result_d = b_val;
      OpMvn:        result_d = ~b_val;
      default:      result_d = sum[31:0];
    endcase

    flags_d        = flags_q;
    flags_d[FlagN] = result_d[31];
    flags_d[FlagZ] = (result_d == 32'd0);
    if (arith) begin
      flags_d[FlagC] = sum[32];
      flags_d[FlagV] = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
    end else begin
      flags_d[FlagC] = shc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (bus.en) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_shifter_unit.sv
// Directed-vector bench for alu_shifter_unit; expected values are hand-computed.
// Flag vectors below are written {N,Z,C,V}.
module tb_alu_shifter_unit;
  import alu_shifter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_shifter_unit_if bus ();

  alu_shifter_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] m, input logic [11:0] f, input logic [2:0] st,
                       input logic ci);
    bus.en          = en;
    bus.opcode      = op;
    bus.rn          = a;
    bus.rm          = m;
    bus.shift_field = f;
    bus.shift_type  = st;
    bus.carry_in    = ci;
  endtask

  task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] m, input logic [11:0] f, input logic [2:0] st,
                         input logic ci, input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    drive(1'b1, op, a, m, f, st, ci);
    @(posedge clk);
    #1;
    check_val({tag, "_res"}, bus.result, exp_r);
    check_val({tag, "_flg"}, {28'b0, bus.flags}, {28'b0, exp_f});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, OpAnd, 32'd0, 32'd0, 12'd0, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_res", bus.result, 32'd0);
    check_val("rst_flg", {28'b0, bus.flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: nothing visible until the enabled edge.
    @(negedge clk);
    drive(1'b1, OpAdd, 32'd6, 32'd10, 12'd0, 3'b100, 1'b0);
    #1;
    check_val("lat_pre", bus.result, 32'd0);
    @(posedge clk);
    #1;
    check_val("add_small_res", bus.result, 32'd16);
    check_val("add_small_flg", {28'b0, bus.flags}, 32'd0);

    run_vec("add_ovf", OpAdd, 32'h80006172, 32'h80310333, 12'h000, 3'b100, 1'b0,
            32'h003164A5, 4'b0011);
    run_vec("sub_zero", OpSub, 32'd5, 32'd5, 12'h000, 3'b100, 1'b0, 32'd0, 4'b0110);
    run_vec("add_ovf2", OpAdd, 32'h80006172, 32'h80310333, 12'h000, 3'b100, 1'b0,
            32'h003164A5, 4'b0011);
    run_vec("mov_lsl7", OpMov, 32'd0, 32'hEB000007, 12'h387, 3'b000, 1'b0,
            32'h80000380, 4'b1011);
    run_vec("mov_imm", OpMov, 32'd0, 32'd0, 12'h387, 3'b001, 1'b1, 32'h1C000002, 4'b0001);
    run_vec("mov_lsimm", OpMov, 32'd0, 32'd0, 12'h5D5, 3'b010, 1'b0, 32'h000005D5, 4'b0001);
    run_vec("imm_rot0", OpMov, 32'd0, 32'd0, 12'h0FF, 3'b001, 1'b1, 32'h000000FF, 4'b0011);
`ifdef ALU_SHIFTER_RRX_EN
    run_vec("ror0", OpMov, 32'd0, 32'h00000003, 12'h060, 3'b000, 1'b1, 32'h80000001, 4'b1011);
`else
    run_vec("ror0", OpMov, 32'd0, 32'h00000003, 12'h060, 3'b000, 1'b1, 32'h00000003, 4'b0011);
`endif
    run_vec("lsr0", OpMov, 32'd0, 32'h80000000, 12'h020, 3'b000, 1'b0, 32'd0, 4'b0111);
    run_vec("asr0", OpMov, 32'd0, 32'h80000000, 12'h040, 3'b000, 1'b0, 32'hFFFFFFFF, 4'b1011);
    run_vec("asr4", OpMov, 32'd0, 32'h80000010, 12'h240, 3'b000, 1'b1, 32'hF8000001, 4'b1001);
    run_vec("lsr4", OpMov, 32'd0, 32'h000000F8, 12'h220, 3'b000, 1'b0, 32'h0000000F, 4'b0011);
    run_vec("ror8", OpMov, 32'd0, 32'h000000A5, 12'h460, 3'b000, 1'b0, 32'hA5000000, 4'b1011);
    run_vec("lsreg0", OpMov, 32'd0, 32'h00001234, 12'h00F, 3'b011, 1'b0, 32'h00001234, 4'b0001);
    run_vec("rsb", OpRsb, 32'd3, 32'd10, 12'h000, 3'b100, 1'b0, 32'd7, 4'b0010);
    run_vec("sbc", OpSbc, 32'd5, 32'd7, 12'h000, 3'b100, 1'b0, 32'hFFFFFFFD, 4'b1000);
    run_vec("sbc_c1", OpSbc, 32'd5, 32'd7, 12'h000, 3'b100, 1'b1, 32'hFFFFFFFE, 4'b1000);
    run_vec("adc", OpAdc, 32'hFFFFFFFF, 32'd0, 12'h000, 3'b100, 1'b1, 32'd0, 4'b0110);
    run_vec("bic", OpBic, 32'h000000FF, 32'h0000000F, 12'h000, 3'b100, 1'b1, 32'h000000F0,
            4'b0010);
    run_vec("tst", OpTst, 32'h000000F0, 32'h0000000F, 12'h000, 3'b100, 1'b0, 32'd0, 4'b0100);
    run_vec("cmp", OpCmp, 32'd3, 32'd5, 12'h000, 3'b100, 1'b0, 32'hFFFFFFFE, 4'b1000);
    run_vec("rsc", OpRsc, 32'd5, 32'd3, 12'h000, 3'b100, 1'b0, 32'hFFFFFFFD, 4'b1000);
    run_vec("cmn", OpCmn, 32'h7FFFFFFF, 32'd1, 12'h000, 3'b100, 1'b0, 32'h80000000, 4'b1001);
    run_vec("eor", OpEor, 32'h000000FF, 32'h0000000F, 12'h000, 3'b100, 1'b0, 32'h000000F0,
            4'b0001);
    run_vec("mvn", OpMvn, 32'd0, 32'd0, 12'h000, 3'b100, 1'b0, 32'hFFFFFFFF, 4'b1001);
    run_vec("teq", OpTeq, 32'd5, 32'd5, 12'h000, 3'b100, 1'b1, 32'd0, 4'b0111);
    run_vec("orr", OpOrr, 32'h000000F0, 32'h0000000F, 12'h000, 3'b100, 1'b0, 32'h000000FF,
            4'b0001);
    run_vec("and", OpAnd, 32'h000000F0, 32'h0000003C, 12'h000, 3'b100, 1'b1, 32'h00000030,
            4'b0011);

    // en=0: inputs churn, registers must hold.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, OpSub, 32'd100 + i, 32'd7 * i, 12'h123, 3'(i), 1'b0);
      @(posedge clk);
      #1;
      check_val("hold_res", bus.result, 32'h00000030);
      check_val("hold_flg", {28'b0, bus.flags}, 32'h3);
    end

    // Asynchronous reset between edges, with en high.
    @(negedge clk);
    drive(1'b1, OpAdd, 32'd1, 32'd2, 12'h000, 3'b100, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("arst_res", bus.result, 32'd0);
    check_val("arst_flg", {28'b0, bus.flags}, 32'd0);
    @(posedge clk);
    #1;
    check_val("arst_hold", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_res", bus.result, 32'd3);
    check_val("post_rst_flg", {28'b0, bus.flags}, 32'd0);

    @(negedge clk);
    bus.en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
